// File: rtl/spart_pkg.sv
// Shared types and frame constants for the SPART transmitter.
// SPART_TX_PARITY_EN adds the even-parity state to the FSM encoding.
package spart_pkg;

  localparam int   DATA_BITS        = 8;
  localparam logic START_LEVEL      = 1'b0;
  localparam logic STOP_LEVEL       = 1'b1;
  localparam int   DEFAULT_BAUD_DIV = 434;

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } tx_state_e;
`endif

endpackage

// File: rtl/spart_tx_fifo.sv
// Byte FIFO for the SPART transmitter; full/empty derive from the registered count.
module spart_tx_fifo
  import spart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop_ok)      count <= count + (AW+1)'(1);
      else if (pop_ok && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spart_tx.sv
// SPART transmit path: FIFO-buffered 8N1 serialiser with registered txd.
// Define SPART_TX_PARITY_EN to insert an even-parity bit after the data bits.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | line high; pops next byte when FIFO not empty
// ST_START  | start bit (low) for BAUD_DIV clocks
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | even parity of the byte (parity build only)
// ST_STOP   | stop bit (high) for BAUD_DIV clocks
module spart_tx
  import spart_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 txd
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(BAUD_DIV - 1);

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic                 txd_q, txd_d;
  logic                 bit_end;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_rdata;
`ifdef SPART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  spart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (send),
    .wdata (tx_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  assign bit_end = (baud_q == '0);
  assign pop     = (state_q == ST_IDLE) && !empty;
  assign busy    = (state_q != ST_IDLE);
  assign txd     = txd_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!empty) state_d = ST_START;
      ST_START: if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end && bit_idx_q == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SPART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
      ST_STOP:  if (bit_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next values; txd is derived from the next state so the
  // registered line changes on the same edge as the state.
  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    baud_d    = baud_q;
`ifdef SPART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (pop) begin
      shift_d   = fifo_rdata;
      bit_idx_d = '0;
      baud_d    = BAUD_LOAD;
`ifdef SPART_TX_PARITY_EN
      parity_d  = ^fifo_rdata;
`endif
    end else if (state_q != ST_IDLE) begin
      if (bit_end) begin
        baud_d = BAUD_LOAD;
        if (state_q == ST_DATA) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end else begin
        baud_d = baud_q - BW'(1);
      end
    end

    txd_d = STOP_LEVEL;
    case (state_d)
      ST_IDLE:   txd_d = STOP_LEVEL;
      ST_START:  txd_d = START_LEVEL;
      ST_DATA:   txd_d = shift_d[0];
`ifdef SPART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      ST_STOP:   txd_d = STOP_LEVEL;
      default:   txd_d = STOP_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
      baud_q    <= '0;
      txd_q     <= STOP_LEVEL;
`ifdef SPART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      baud_q    <= baud_d;
      txd_q     <= txd_d;
`ifdef SPART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: a queue-based line model predicts txd/busy/full/empty every clock.
module tb_spart_tx;

  localparam int DEPTH = 4;
  localparam int BD    = 4;
`ifdef SPART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [7:0] tx_data;
  logic       full, empty, busy, txd;

  int checks = 0;
  int errors = 0;

  // Model: bytes waiting in the FIFO, and the per-clock {busy,txd} timeline of the frame in flight.
  logic [7:0] mq[$];
  logic [1:0] line[$];
  logic       exp_txd  = 1'b1;
  logic       exp_busy = 1'b0;

  spart_tx #(.DEPTH(DEPTH), .BAUD_DIV(BD)) dut (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .tx_data (tx_data),
    .full    (full),
    .empty   (empty),
    .busy    (busy),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic load_frame(logic [7:0] b);
    logic lv[$];
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
`ifdef SPART_TX_PARITY_EN
    lv.push_back(^b);
`endif
    lv.push_back(1'b1);
    foreach (lv[k]) for (int j = 0; j < BD; j++) line.push_back({1'b1, lv[k]});
    line.push_back(2'b01);
  endtask

  task automatic model_step();
    logic [1:0] e;
    bit was_full;
    if (rst) begin
      mq.delete();
      line.delete();
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    if (line.size() == 0 && mq.size() != 0) load_frame(mq.pop_front());
    if (line.size() != 0) begin
      e = line.pop_front();
      exp_busy = e[1];
      exp_txd  = e[0];
    end else begin
      exp_busy = 1'b0;
      exp_txd  = 1'b1;
    end
    if (send && !was_full) mq.push_back(tx_data);
  endtask

  task automatic cycle(logic s, logic [7:0] d);
    send    = s;
    tx_data = d;
    @(posedge clk);
    model_step();
    #1;
    chk("txd", txd, exp_txd);
    chk("busy", busy, exp_busy);
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
  endtask

  task automatic drain(int limit);
    int n = 0;
    while ((line.size() != 0 || mq.size() != 0) && n < limit) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    checks++;
    if (n >= limit) begin
      errors++;
      $display("FAIL drain_timeout observed=%0d cycles required<%0d", n, limit);
    end
  endtask

  // Push one byte into an idle, empty block and sample the middle of each bit slot.
  task automatic capture_frame(logic [7:0] b, output logic [10:0] bits);
    bits = '1;
    cycle(1'b1, b);
    for (int k = 0; k < FBITS; k++)
      for (int j = 0; j < BD; j++) begin
        cycle(1'b0, 8'h00);
        if (j == 1) bits[k] = txd;
      end
    cycle(1'b0, 8'h00);
  endtask

  initial begin
    logic [10:0] got;
    logic [9:0]  a5_ref;
    int          n;

    rst = 1'b1; send = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);

    // Directed 0xA5 frame: start + LSB-first data + stop.
    a5_ref = 10'b1101001010;
    capture_frame(8'hA5, got);
    for (int k = 0; k < 9; k++) chk("a5_bit", got[k], a5_ref[k]);
    chk("a5_stop", got[FBITS-1], 1'b1);
    chk("a5_busy_after", busy, 1'b0);

`ifdef SPART_TX_PARITY_EN
    capture_frame(8'h07, got);
    chk("par_07", got[9], 1'b1);
    capture_frame(8'h03, got);
    chk("par_03", got[9], 1'b0);
`endif

    // Five consecutive pushes while a frame is on the line: fifth dropped.
    cycle(1'b1, 8'h3C);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom));
    chk("five_push_full", full, 1'b1);

    // Send exactly on the pop edge while full: dropped, then retried.
    n = 0;
    while (!(line.size() == 0 && mq.size() == DEPTH) && n < 500) begin
      cycle(1'b0, 8'h00);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL full_pop_wait observed=%0d cycles required<500", n);
    end
    cycle(1'b1, 8'hE1);
    chk("drop_full_cleared", full, 1'b0);
    cycle(1'b1, 8'h5A);
    chk("retry_full", full, 1'b1);
    drain(2000);

    // Reset in the middle of data bit 3 with bytes still queued.
    cycle(1'b1, 8'h96);
    cycle(1'b1, 8'h69);
    cycle(1'b1, 8'hF0);
    for (int i = 0; i < 4 * BD - 1; i++) cycle(1'b0, 8'h00);
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    chk("rst_txd", txd, 1'b1);
    chk("rst_empty", empty, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) cycle(1'b0, 8'h00);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) cycle($urandom_range(0, 5) == 0, 8'($urandom));
    drain(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
